// File: rtl/zero_random_prng_pkg.sv
// -----------------------------------------------------------------------------
// zero_random_prng_pkg
// Shared constants and types for the zero_random_prng generator that feeds the
// in_random bus of the masked shared-zero stage.
//   PRNG_POLY        : feedback tap mask for x^64+x^63+x^61+x^60+1
//                      (state bits 63, 62, 60, 59 feed the new bit 0)
//   PRNG_SEED_FIXUP  : substituted for an all-zero seed (the LFSR would lock up)
//   RESEED_INTERVAL  : default word count before a reseed request is raised
//   prng_state_t     : generator FSM states
//   num_zero_random  : random elements consumed per cycle by an n-share stage
// -----------------------------------------------------------------------------
package zero_random_prng_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARMUP   = 2'd1,
    RUN      = 2'd2
  } prng_state_t;

  localparam logic [63:0] PRNG_POLY       = 64'hD800_0000_0000_0000;
  localparam logic [63:0] PRNG_SEED_FIXUP = 64'h0000_0000_0000_0001;
  localparam int unsigned RESEED_INTERVAL = 32'd1048576;

  // One fresh element per unordered pair of shares.
  function automatic int num_zero_random(input int num_shares);
    return (num_shares * (num_shares - 32'sd1)) / 32'sd2;
  endfunction

endpackage

// File: rtl/zero_random_prng_lfsr_step.sv
// -----------------------------------------------------------------------------
// zero_random_prng_lfsr_step
// Combinational advance of a Fibonacci LFSR by OUT_BITS single-bit shifts.
// Each shift moves the state one place towards the MSB and inserts the XOR of
// the tapped bits (PRNG_POLY mask) at bit 0.
// Ports:
//   state      in  STATE_WIDTH : current LFSR state
//   next_state out STATE_WIDTH : state after OUT_BITS shifts
// -----------------------------------------------------------------------------
module zero_random_prng_lfsr_step
  import zero_random_prng_pkg::*;
#(
  parameter int STATE_WIDTH = 64,
  parameter int OUT_BITS    = 2
) (
  input  logic [STATE_WIDTH-1:0] state,
  output logic [STATE_WIDTH-1:0] next_state
);

  // Unrolled shift chain; a nonzero state can never map to zero because the
  // x^0 term makes every single shift invertible.
  always_comb begin
    logic [STATE_WIDTH-1:0] work_s;
    work_s = state;
    for (int i = 0; i < OUT_BITS; i++) begin
      work_s = {work_s[STATE_WIDTH-2:0], ^(work_s & PRNG_POLY)};
    end
    next_state = work_s;
  end

endmodule

// File: rtl/zero_random_prng.sv
// -----------------------------------------------------------------------------
// zero_random_prng
// Seedable LFSR random source for the masked shared-zero stage. A seed is
// taken over a valid/ready handshake, the generator discards WARMUP_CYCLES
// steps, then delivers one registered word of NUM_NEEDED*BIT_WIDTH bits per
// enabled cycle with a valid flag.
// Optional feature macro: ZERO_PRNG_RESEED_REQ_EN adds a word counter and the
// out_reseed_req port (sticky until the next seed accept).
// Ports:
//   in_clock        in  : clock
//   in_reset        in  : synchronous active-high reset
//   in_seed         in  : seed value (STATE_WIDTH)
//   in_seed_valid   in  : seed offered
//   out_seed_ready  out : seed accepted this cycle if offered (not in WARMUP)
//   in_enable       in  : advance generator while in RUN
//   out_random      out : registered random word, NUM_NEEDED x BIT_WIDTH
//   out_valid       out : out_random holds a fresh word this cycle
//   out_reseed_req  out : (macro only) word budget exhausted, reseed wanted
// -----------------------------------------------------------------------------
module zero_random_prng
  import zero_random_prng_pkg::*;
#(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 2,
  parameter int STATE_WIDTH   = 64,
  parameter int WARMUP_CYCLES = 16
`ifdef ZERO_PRNG_RESEED_REQ_EN
  ,
  parameter int unsigned RESEED_INTERVAL_CFG = RESEED_INTERVAL
`endif
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic [STATE_WIDTH-1:0] in_seed,
  input  logic                   in_seed_valid,
  output logic                   out_seed_ready,
  input  logic                   in_enable,
  output logic [num_zero_random(NUM_SHARES)-1:0][BIT_WIDTH-1:0] out_random,
  output logic                   out_valid
`ifdef ZERO_PRNG_RESEED_REQ_EN
  ,
  output logic                   out_reseed_req
`endif
);

  localparam int NUM_NEEDED = num_zero_random(NUM_SHARES);
  localparam int OUT_BITS   = NUM_NEEDED * BIT_WIDTH;
  localparam logic [7:0] WARMUP_LOAD = 8'(WARMUP_CYCLES);

  if (STATE_WIDTH != 64) begin : g_bad_state_width
    $error("zero_random_prng: STATE_WIDTH must be 64");
  end
  if (OUT_BITS < 1 || OUT_BITS > STATE_WIDTH) begin : g_bad_out_bits
    $error("zero_random_prng: NUM_NEEDED*BIT_WIDTH must be 1..STATE_WIDTH");
  end
  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
    $error("zero_random_prng: WARMUP_CYCLES must be 1..255");
  end

  prng_state_t            state_r;
  prng_state_t            state_s;
  logic [STATE_WIDTH-1:0] lfsr_r;
  logic [STATE_WIDTH-1:0] lfsr_s;
  logic [STATE_WIDTH-1:0] stepped_s;
  logic [STATE_WIDTH-1:0] seed_load_s;
  logic [7:0]             warm_cnt_r;
  logic [7:0]             warm_cnt_s;
  logic [OUT_BITS-1:0]    rnd_r;
  logic [OUT_BITS-1:0]    rnd_s;
  logic                   valid_r;
  logic                   valid_s;
  logic                   accept_s;

  zero_random_prng_lfsr_step #(
    .STATE_WIDTH (STATE_WIDTH),
    .OUT_BITS    (OUT_BITS)
  ) u_lfsr_step (
    .state      (lfsr_r),
    .next_state (stepped_s)
  );

  // Handshake decode: ready depends only on the registered FSM state.
  always_comb begin
    out_seed_ready = (state_r != WARMUP);
    accept_s       = in_seed_valid & out_seed_ready;
    if (in_seed == {STATE_WIDTH{1'b0}}) begin
      seed_load_s = PRNG_SEED_FIXUP;
    end else begin
      seed_load_s = in_seed;
    end
  end

  // Next-state logic for the FSM, LFSR, warm-up counter and output word.
  always_comb begin
    state_s    = state_r;
    lfsr_s     = lfsr_r;
    warm_cnt_s = warm_cnt_r;
    rnd_s      = rnd_r;
    valid_s    = 1'b0;
    case (state_r)
      UNSEEDED: begin
        if (accept_s) begin
          lfsr_s     = seed_load_s;
          warm_cnt_s = WARMUP_LOAD;
          rnd_s      = {OUT_BITS{1'b0}};
          state_s    = WARMUP;
        end else begin
          state_s = UNSEEDED;
        end
      end
      WARMUP: begin
        lfsr_s     = stepped_s;
        warm_cnt_s = warm_cnt_r - 8'd1;
        rnd_s      = {OUT_BITS{1'b0}};
        if (warm_cnt_r == 8'd1) begin
          state_s = RUN;
        end else begin
          state_s = WARMUP;
        end
      end
      RUN: begin
        // A reseed beats a simultaneous enable.
        if (accept_s) begin
          lfsr_s     = seed_load_s;
          warm_cnt_s = WARMUP_LOAD;
          rnd_s      = {OUT_BITS{1'b0}};
          state_s    = WARMUP;
        end else if (in_enable) begin
          lfsr_s  = stepped_s;
          rnd_s   = stepped_s[OUT_BITS-1:0];
          valid_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s    = UNSEEDED;
        lfsr_s     = PRNG_SEED_FIXUP;
        warm_cnt_s = 8'd0;
        rnd_s      = {OUT_BITS{1'b0}};
      end
    endcase
  end

  // State and output registers; reset overrides any simultaneous accept.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_r    <= UNSEEDED;
      lfsr_r     <= PRNG_SEED_FIXUP;
      warm_cnt_r <= 8'd0;
      rnd_r      <= {OUT_BITS{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      lfsr_r     <= lfsr_s;
      warm_cnt_r <= warm_cnt_s;
      rnd_r      <= rnd_s;
      valid_r    <= valid_s;
    end
  end

  assign out_random = rnd_r;
  assign out_valid  = valid_r;

`ifdef ZERO_PRNG_RESEED_REQ_EN
  logic [31:0] word_cnt_r;
  logic [31:0] word_cnt_s;
  logic        reseed_req_r;
  logic        reseed_req_s;

  // Word budget: counts delivered words since the last seed, request is sticky.
  always_comb begin
    word_cnt_s   = word_cnt_r;
    reseed_req_s = reseed_req_r;
    if (accept_s) begin
      word_cnt_s   = 32'd0;
      reseed_req_s = 1'b0;
    end else if (valid_s) begin
      word_cnt_s = word_cnt_r + 32'd1;
      if (word_cnt_s == RESEED_INTERVAL_CFG) begin
        reseed_req_s = 1'b1;
      end else begin
        reseed_req_s = reseed_req_r;
      end
    end else begin
      word_cnt_s = word_cnt_r;
    end
  end

  // Word counter and request registers.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      word_cnt_r   <= 32'd0;
      reseed_req_r <= 1'b0;
    end else begin
      word_cnt_r   <= word_cnt_s;
      reseed_req_r <= reseed_req_s;
    end
  end

  assign out_reseed_req = reseed_req_r;
`endif

endmodule
